pilha_lifo: RTL

PILHA_LIFO -- requirements
Module: pilha_lifo

---
 rtl/pilha_lifo.sv | 108 ++++++++++
 1 files changed

// File: rtl/pilha_lifo.sv
// LIFO stack with push, pop and replace operations, plus a sticky error state
// that is entered on overflow or underflow and left only through limpa_erro.
module pilha_lifo #(
  parameter int LARGURA      = 16,
  parameter int PROFUNDIDADE = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [LARGURA-1:0]              data_in,
  input  logic                            limpa_erro,
  output logic [LARGURA-1:0]              topo,
  output logic [LARGURA-1:0]              segundo,
  output logic [$clog2(PROFUNDIDADE):0]   contagem,
  output logic                            vazia,
  output logic                            cheia,
  output logic                            erro,
  output logic [1:0]                      codigo_erro
);
  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0] CHEIO = (PW+1)'(PROFUNDIDADE);

  typedef enum logic {OCIOSO, ERRO} estado_t;

  estado_t               estado_q;
  logic [PW:0]           cnt_q;
  logic                  erro_q;
  logic [1:0]            cod_q;
  logic [LARGURA-1:0]    mem_q [PROFUNDIDADE];

  logic [PW-1:0] ptr, ptr_m1, ptr_m2, wr_idx;
  logic          wr_en, inc, dec, ovf, udf;

  // Index arithmetic wraps in PW bits on purpose: at a full stack ptr is 0,
  // so ptr-1 lands on the last entry.
  assign ptr    = cnt_q[PW-1:0];
  assign ptr_m1 = ptr - 1'b1;
  assign ptr_m2 = ptr - 2'd2;

  assign vazia = (cnt_q == '0);
  assign cheia = (cnt_q == CHEIO);

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = ptr;
    inc    = 1'b0;
    dec    = 1'b0;
    ovf    = 1'b0;
    udf    = 1'b0;
    if (!reset && estado_q == OCIOSO) begin
      if (push && !pop) begin
        if (cheia) ovf = 1'b1;
        else begin
          wr_en = 1'b1;
          inc   = 1'b1;
        end
      end else if (pop) begin
        if (vazia) udf = 1'b1;
        else if (push) begin
          wr_en  = 1'b1;
          wr_idx = ptr_m1;
        end else dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      erro_q   <= 1'b0;
      cod_q    <= 2'b00;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (inc) cnt_q <= cnt_q + 1'b1;
          if (dec) cnt_q <= cnt_q - 1'b1;
          if (ovf || udf) begin
            estado_q <= ERRO;
            erro_q   <= 1'b1;
            cod_q    <= ovf ? 2'b01 : 2'b10;
          end
        end
        ERRO: begin
          // Operations on the clearing edge are dropped; only the state moves.
          if (limpa_erro) begin
            estado_q <= OCIOSO;
            erro_q   <= 1'b0;
            cod_q    <= 2'b00;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  // Storage is not reset: entries at or above contagem are never observable.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_idx] <= data_in;
  end

  assign topo        = (cnt_q >= (PW+1)'(1)) ? mem_q[ptr_m1] : '0;
  assign segundo     = (cnt_q >= (PW+1)'(2)) ? mem_q[ptr_m2] : '0;
  assign contagem    = cnt_q;
  assign erro        = erro_q;
  assign codigo_erro = cod_q;
endmodule
